// File: rtl/instr_fetch.sv
// instr_fetch: single-issue instruction fetch stage with an internal
// word-addressed instruction memory and a program-load write port.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned fetches
// into a FAULT state. Without it, pc[1:0] is ignored and fetch_fault is 0.
module instr_fetch #(
    parameter int                XLEN       = 32,
    parameter int                IMEM_DEPTH = 64,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    localparam int               AW         = $clog2(IMEM_DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            imem_we,
    input  logic [AW-1:0]   imem_waddr,
    input  logic [XLEN-1:0] imem_wdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_out,
    output logic            fetch_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] ipc_q, ipc_d;
    logic [XLEN-1:0] iout_q, iout_d;

    // Instruction storage; deliberately not reset so a loaded program
    // survives a reset. Contents are undefined until written.
    logic [XLEN-1:0] mem [IMEM_DEPTH];

    // Word index: upper PC bits alias, low two bits never address memory.
    logic [AW-1:0]   rd_idx;
    assign rd_idx = pc_q[AW+1:2];

    // Next-state and output-register computation; redirect beats stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        ipc_d   = ipc_q;
        iout_d  = iout_q;
        case (state_q)
            IDLE: begin
                // One-cycle settle after reset; a redirect is still taken.
                state_d = RUN;
                valid_d = 1'b0;
                if (redirect_valid) pc_d = redirect_pc;
            end
            RUN: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end else if (!stall) begin
`ifdef FETCH_MISALIGN_TRAP_EN
                    if (pc_q[1:0] != 2'b00) begin
                        // Freeze pc at the offending address for the handler.
                        state_d = FAULT;
                        valid_d = 1'b0;
                    end else
`endif
                    begin
                        iout_d  = mem[rd_idx];
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end
                end
            end
            FAULT: begin
                // Only a redirect (or reset) gets out of a fault.
                if (redirect_valid) begin
                    state_d = RUN;
                    pc_d    = redirect_pc;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            ipc_q   <= '0;
            iout_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            ipc_q   <= ipc_d;
            iout_q  <= iout_d;
        end
    end

    // Program-load write port; a same-cycle fetch sees the pre-write word.
    always_ff @(posedge clk) begin
        if (imem_we) mem[imem_waddr] <= imem_wdata;
    end

    assign instr_valid = valid_q;
    assign instr_pc    = ipc_q;
    assign instr_out   = iout_q;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = (state_q == FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/instruction width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 64, number of instruction words (power of two, >=4).
REQ-003 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port stall  input  1  hold the PC and output registers.
REQ-007 SHALL have port redirect_valid  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc  input  XLEN  redirect target byte address.
REQ-009 SHALL have ports imem_we (input, 1), imem_waddr (input, log2(IMEM_DEPTH)), imem_wdata (input, XLEN), a word-indexed program-load write port.
REQ-010 SHALL have ports instr_valid (output, 1), instr_pc (output, XLEN), instr_out (output, XLEN), the registered fetch result.
REQ-011 SHALL have port fetch_fault  output  1  misaligned-fetch flag (driven 0 when REQ-026 is disabled).

Function
REQ-012 SHALL implement the states IDLE, RUN and FAULT; IDLE lasts exactly one cycle after reset, then RUN.
REQ-013 IDLE SHALL present pc=RESET_PC and instr_valid=0, and SHALL not fetch.
REQ-014 In RUN with stall=0 and redirect_valid=0, SHALL register instr_out<=mem[pc>>2], instr_pc<=pc, instr_valid<=1 and pc<=pc+4; latency is 1 cycle.
REQ-015 PC increment SHALL wrap modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32).
REQ-016 The word index SHALL be pc[log2(IMEM_DEPTH)+1:2]; upper PC bits SHALL be ignored, so addresses alias modulo 4*IMEM_DEPTH.
REQ-017 With stall=1 and redirect_valid=0, pc, instr_out, instr_pc and instr_valid SHALL hold their values.
REQ-018 redirect_valid=1 SHALL take priority over stall: pc<=redirect_pc and instr_valid<=0 in the next cycle (one bubble), with fetch resuming at redirect_pc the cycle after.
REQ-019 A redirect in IDLE SHALL be honoured; the transition to RUN still occurs.
REQ-020 imem_we=1 SHALL write mem[imem_waddr]<=imem_wdata whatever the state or stall.
REQ-021 A same-cycle write and fetch of the same word SHALL return the old (pre-write) data.
REQ-022 Memory SHALL be read-only from the fetch side, and its contents SHALL be undefined until written.

Reset
REQ-023 reset=1 at a rising edge SHALL set state=IDLE, pc=RESET_PC, instr_valid=0, instr_pc=0, instr_out=0 and fetch_fault=0.
REQ-024 Reset SHALL override stall, redirect and any in-progress fault, including a reset asserted mid-RUN.
REQ-025 Reset SHALL NOT clear the memory array, so a program loaded before reset survives it.

Configuration
REQ-026 With macro FETCH_MISALIGN_TRAP_EN defined, a RUN fetch with pc[1:0]!=0 SHALL enter FAULT, set fetch_fault=1 and instr_valid=0, and freeze pc.
REQ-027 FAULT SHALL be left only by reset (to IDLE) or by redirect_valid (to RUN, with fetch_fault cleared next cycle).
REQ-028 Without the macro, pc[1:0] SHALL be ignored (word-truncated fetch), FAULT SHALL be unreachable, and fetch_fault SHALL be tied to 0.

Verification
REQ-029 Load mem[0..3]=0x11,0x22,0x33,0x44, then reset -> instr_valid first high 2 cycles after reset deasserts, with (instr_pc,instr_out)=(0,0x11),(4,0x22),(8,0x33),(0xC,0x44) on consecutive cycles.
REQ-030 stall=1 for 3 cycles while instr_pc=4 -> instr_pc=4 and instr_out=0x22 held for 3 cycles, then 8/0x33.
REQ-031 redirect_valid=1 with redirect_pc=0xC while stall=1 -> one cycle with instr_valid=0, then instr_pc=0xC and instr_out=0x44.
REQ-032 Redirect to 0xFFFFFFFC with IMEM_DEPTH=64 -> fetches mem[63], then instr_pc=0x00000000 with mem[0].
REQ-033 Macro defined, redirect_pc=0x6 -> fetch_fault=1 and instr_valid=0 held; redirect to 0x8 -> fetch_fault=0 and instr_pc=8 after the bubble. Macro undefined -> instr_out=mem[1] and fetch_fault stays 0.
REQ-034 imem_we writing word 2 with 0xAA in the same cycle that pc=8 is fetched -> instr_out=0x33; a refetch of 8 returns 0xAA.
